// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file writeback port among NUMREQ result streams.
// Optional perf counters (ConflictCount, SquashCount) are enabled by WRITEBACK_ARB_PERF_EN.
module writeback_arbiter #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned NUMREQ       = 4
) (
  input  logic                           clk,
  input  logic                           async_rst_n,
  input  logic                           clk_en,
  input  logic                           WritebackBlock,
  input  logic                           MispredictedSpeculationPulse,
  input  logic [NUMREQ-1:0]              ReqValid,
  input  logic [NUMREQ-1:0]              ReqSpeculative,
  input  logic [NUMREQ*4-1:0]            ReqAddr,
  input  logic [NUMREQ*DATABITWIDTH-1:0] ReqData,
  output logic [NUMREQ-1:0]              ReqReady,
  output logic                           WritebackEn,
  output logic [3:0]                     WritebackRegisterAddr,
  output logic [DATABITWIDTH-1:0]        WritebackData
`ifdef WRITEBACK_ARB_PERF_EN
  ,
  output logic [15:0]                    ConflictCount,
  output logic [15:0]                    SquashCount
`endif
);

  localparam int unsigned PTRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [PTRW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    wb_en_q, wb_en_d;
  logic [3:0]              wb_addr_q, wb_addr_d;
  logic [DATABITWIDTH-1:0] wb_data_q, wb_data_d;

  logic                    found;
  logic [PTRW-1:0]         winner;
  logic [PTRW-1:0]         cand;
  logic                    grant_active;
  logic                    transfer;
  logic                    squash;
  logic [NUMREQ-1:0]       grant_onehot;
  logic [3:0]              win_addr;
  logic [DATABITWIDTH-1:0] win_data;
  logic                    win_spec;

  // Grant is masked during reset so no requester sees a handshake it cannot complete.
  assign grant_active = clk_en & ~WritebackBlock & async_rst_n;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      cand = PTRW'((32'(rr_ptr_q) + k) % NUMREQ);
      if (!found && ReqValid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    win_addr     = '0;
    win_data     = '0;
    win_spec     = 1'b0;
    for (int i = 0; i < int'(NUMREQ); i++) begin
      if (winner == PTRW'(i)) begin
        grant_onehot[i] = 1'b1;
        win_addr        = ReqAddr[4*i +: 4];
        win_data        = ReqData[DATABITWIDTH*i +: DATABITWIDTH];
        win_spec        = ReqSpeculative[i];
      end
    end
  end

  assign transfer = found & grant_active;
  assign squash   = transfer & MispredictedSpeculationPulse & win_spec;
  assign ReqReady = transfer ? grant_onehot : '0;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    // Zero-register and squashed results are consumed but never written.
    wb_en_d   = transfer & (win_addr != 4'd0) & ~squash;
    if (transfer) begin
      rr_ptr_d  = (32'(winner) == NUMREQ - 1) ? '0 : winner + 1'b1;
      wb_addr_d = win_addr;
      wb_data_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rr_ptr_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (clk_en) begin
      rr_ptr_q  <= rr_ptr_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign WritebackEn           = wb_en_q;
  assign WritebackRegisterAddr = wb_addr_q;
  assign WritebackData         = wb_data_q;

`ifdef WRITEBACK_ARB_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;
  logic        conflict;

  assign conflict = ~WritebackBlock & ($countones(ReqValid) >= 2);

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    squash_cnt_d   = squash_cnt_q;
    if (conflict && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
    if (squash && squash_cnt_q != 16'hFFFF)     squash_cnt_d   = squash_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      conflict_cnt_q <= '0;
      squash_cnt_q   <= '0;
    end else if (clk_en) begin
      conflict_cnt_q <= conflict_cnt_d;
      squash_cnt_q   <= squash_cnt_d;
    end
  end

  assign ConflictCount = conflict_cnt_q;
  assign SquashCount   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter (NUMREQ=4, DATABITWIDTH=16).
// Perf-counter checks are compiled in when WRITEBACK_ARB_PERF_EN is defined.
module tb_writeback_arbiter;

  localparam logic [15:0] A0 = 16'h4321;  // req i writes register i+1
  localparam logic [15:0] AZ = 16'h4021;  // req 2 targets the zero register
  localparam logic [63:0] D0 = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        WritebackBlock;
  logic        MispredictedSpeculationPulse;
  logic [3:0]  ReqValid;
  logic [3:0]  ReqSpeculative;
  logic [15:0] ReqAddr;
  logic [63:0] ReqData;
  logic [3:0]  ReqReady;
  logic        WritebackEn;
  logic [3:0]  WritebackRegisterAddr;
  logic [15:0] WritebackData;
`ifdef WRITEBACK_ARB_PERF_EN
  logic [15:0] ConflictCount;
  logic [15:0] SquashCount;
`endif

  writeback_arbiter #(
    .DATABITWIDTH(16),
    .NUMREQ      (4)
  ) dut (
    .clk                         (clk),
    .async_rst_n                 (async_rst_n),
    .clk_en                      (clk_en),
    .WritebackBlock              (WritebackBlock),
    .MispredictedSpeculationPulse(MispredictedSpeculationPulse),
    .ReqValid                    (ReqValid),
    .ReqSpeculative              (ReqSpeculative),
    .ReqAddr                     (ReqAddr),
    .ReqData                     (ReqData),
    .ReqReady                    (ReqReady),
    .WritebackEn                 (WritebackEn),
    .WritebackRegisterAddr       (WritebackRegisterAddr),
    .WritebackData               (WritebackData)
`ifdef WRITEBACK_ARB_PERF_EN
    ,
    .ConflictCount               (ConflictCount),
    .SquashCount                 (SquashCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  spec;
    logic        block;
    logic        en;
    logic        pulse;
    logic [15:0] addr;
    logic [3:0]  exp_ready;
    logic        exp_wen;
    logic [3:0]  exp_waddr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] s, input logic b, input logic e,
                     input logic p, input logic [15:0] a, input logic [3:0] er,
                     input logic ew, input logic [3:0] ea, input logic [15:0] ed);
    vec_t t;
    t.valid = v; t.spec = s; t.block = b; t.en = e; t.pulse = p; t.addr = a;
    t.exp_ready = er; t.exp_wen = ew; t.exp_waddr = ea; t.exp_wdata = ed;
    vecs.push_back(t);
  endtask

  initial begin
    // valid  spec   blk en pls addr  ready  wen waddr wdata
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b0001, 1, 4'd1, 16'hD000);  // ptr 0 -> 1
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b0010, 1, 4'd2, 16'hD001);
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b0100, 1, 4'd3, 16'hD002);
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b1000, 1, 4'd4, 16'hD003);
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b0001, 1, 4'd1, 16'hD000);  // wrap, ptr -> 1
    add(4'b0100, 4'b0000, 0, 1, 0, AZ, 4'b0100, 0, 4'd0, 16'hD002);  // zero reg, ptr -> 3
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b1000, 1, 4'd4, 16'hD003);  // ptr was 3, -> 0
    add(4'b0011, 4'b0001, 0, 1, 1, A0, 4'b0001, 0, 4'd1, 16'hD000);  // squashed
    add(4'b0011, 4'b0001, 0, 1, 0, A0, 4'b0010, 1, 4'd2, 16'hD001);
    add(4'b0110, 4'b0001, 0, 1, 1, A0, 4'b0100, 1, 4'd3, 16'hD002);  // non-spec survives pulse
    add(4'b1000, 4'b0000, 0, 1, 0, A0, 4'b1000, 1, 4'd4, 16'hD003);  // ptr -> 0
    add(4'b1010, 4'b0000, 1, 1, 0, A0, 4'b0000, 0, 4'd4, 16'hD003);  // blocked x3
    add(4'b1010, 4'b0000, 1, 1, 0, A0, 4'b0000, 0, 4'd4, 16'hD003);
    add(4'b1010, 4'b0000, 1, 1, 0, A0, 4'b0000, 0, 4'd4, 16'hD003);
    add(4'b1010, 4'b0000, 0, 1, 0, A0, 4'b0010, 1, 4'd2, 16'hD001);  // release: req1, ptr -> 2
    add(4'b1111, 4'b0000, 0, 0, 0, A0, 4'b0000, 1, 4'd2, 16'hD001);  // clk_en low: hold
    add(4'b1111, 4'b0000, 0, 1, 0, A0, 4'b0100, 1, 4'd3, 16'hD002);  // ptr held at 2
    add(4'b0000, 4'b0000, 0, 1, 0, A0, 4'b0000, 0, 4'd3, 16'hD002);  // idle
    add(4'b0001, 4'b0000, 0, 1, 0, A0, 4'b0001, 1, 4'd1, 16'hD000);  // single requester
    add(4'b0001, 4'b0000, 0, 1, 0, A0, 4'b0001, 1, 4'd1, 16'hD000);
    add(4'b1001, 4'b0000, 0, 1, 0, A0, 4'b1000, 1, 4'd4, 16'hD003);  // ptr 1 skips to 3
    add(4'b1001, 4'b0000, 0, 1, 0, A0, 4'b0001, 1, 4'd1, 16'hD000);

    async_rst_n = 1'b0;
    clk_en = 1'b1;
    WritebackBlock = 1'b0;
    MispredictedSpeculationPulse = 1'b0;
    ReqValid = 4'b1111;
    ReqSpeculative = 4'b0000;
    ReqAddr = A0;
    ReqData = D0;

    // Reset state, including across a clock edge while reset is held
    #1;
    check("rst_ready", 32'(ReqReady), 32'h0);
    @(posedge clk); #1;
    check("rst_wen", 32'(WritebackEn), 32'h0);
    check("rst_waddr", 32'(WritebackRegisterAddr), 32'h0);
    check("rst_wdata", 32'(WritebackData), 32'h0);
    check("rst_ready_held", 32'(ReqReady), 32'h0);
    @(negedge clk);
    async_rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      ReqValid = vecs[i].valid;
      ReqSpeculative = vecs[i].spec;
      WritebackBlock = vecs[i].block;
      clk_en = vecs[i].en;
      MispredictedSpeculationPulse = vecs[i].pulse;
      ReqAddr = vecs[i].addr;
      #1;
      check($sformatf("v%0d_ready", i), 32'(ReqReady), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d_wen", i), 32'(WritebackEn), 32'(vecs[i].exp_wen));
      check($sformatf("v%0d_waddr", i), 32'(WritebackRegisterAddr), 32'(vecs[i].exp_waddr));
      check($sformatf("v%0d_wdata", i), 32'(WritebackData), 32'(vecs[i].exp_wdata));
    end

    // Asynchronous reset between edges discards the pending write at once
    #2;
    async_rst_n = 1'b0;
    #1;
    check("arst_wen", 32'(WritebackEn), 32'h0);
    check("arst_waddr", 32'(WritebackRegisterAddr), 32'h0);
    check("arst_ready", 32'(ReqReady), 32'h0);
    @(negedge clk);
    async_rst_n = 1'b1;
    ReqValid = 4'b1111;
    ReqSpeculative = 4'b0000;
    MispredictedSpeculationPulse = 1'b0;
    #1;
    check("arst_ptr0_ready", 32'(ReqReady), 32'h1);
    @(posedge clk); #1;
    check("arst_ptr0_wen", 32'(WritebackEn), 32'h1);
    check("arst_ptr0_waddr", 32'(WritebackRegisterAddr), 32'h1);

`ifdef WRITEBACK_ARB_PERF_EN
    @(negedge clk);
    async_rst_n = 1'b0;
    #1;
    check("perf_rst_conflict", 32'(ConflictCount), 32'h0);
    check("perf_rst_squash", 32'(SquashCount), 32'h0);
    async_rst_n = 1'b1;
    ReqValid = 4'b0110;
    repeat (5) @(posedge clk);
    #1;
    ReqValid = 4'b0000;
    check("perf_conflict5", 32'(ConflictCount), 32'd5);
    @(negedge clk);
    ReqValid = 4'b0001;
    ReqSpeculative = 4'b0001;
    MispredictedSpeculationPulse = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ReqValid = 4'b0000;
    MispredictedSpeculationPulse = 1'b0;
    check("perf_squash2", 32'(SquashCount), 32'd2);
    check("perf_conflict_hold", 32'(ConflictCount), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the register file's single writeback port (WritebackEn/WritebackRegisterAddr/WritebackData) between NUMREQ functional-unit result streams.
- Round-robin grant, valid/ready per requester, one registered output stage.
- Squashes speculative results on misprediction and suppresses writes to the zero register.
- Sits between the execution units and the register file writeback input.

Parameters:
- DATABITWIDTH, 16, result data width; matches the register file.
- NUMREQ, 4, number of requesters (2..8).
- PTRW, $clog2(NUMREQ), round-robin pointer width (derived, not overridden).

Ports:
- clk  in  1  clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; all state holds when low
- WritebackBlock  in  1  high = no grant this cycle (register file port reserved)
- MispredictedSpeculationPulse  in  1  one-cycle squash of speculative results
- ReqValid  in  NUMREQ  requester i has a result
- ReqSpeculative  in  NUMREQ  requester i result is speculative
- ReqAddr  in  NUMREQ*4  packed destination register addresses, [4i+3:4i]
- ReqData  in  NUMREQ*DATABITWIDTH  packed result data
- ReqReady  out  NUMREQ  grant, one-hot or zero, combinational
- WritebackEn  out  1  to register file
- WritebackRegisterAddr  out  4  to register file
- WritebackData  out  DATABITWIDTH  to register file

Behaviour:
- Reset (async_rst_n low, asynchronous): WritebackEn=0, WritebackRegisterAddr=0, WritebackData=0, RR pointer=0. ReqReady=0 while reset is asserted.
- Grant (combinational):
  - Active when clk_en=1 and WritebackBlock=0.
  - Winner = first i with ReqValid[i]=1, searching from RR pointer upward with wrap modulo NUMREQ.
  - ReqReady[winner]=1; all other bits 0. No valid requester gives ReqReady=0.
- Handshake:
  - Transfer occurs when ReqValid[i] & ReqReady[i].
  - Requesters hold Valid/Addr/Data/Speculative stable until the transfer.
  - Ready never depends on ReqData.
- Output register, updated on a rising clk with clk_en=1:
  - WritebackEn <= transfer & (winner addr != 0) & ~(MispredictedSpeculationPulse & ReqSpeculative[winner]).
  - Addr/Data are loaded from the winner on any transfer; they hold otherwise.
  - Latency is exactly 1 cycle from transfer to WritebackEn.
- Zero register: address 0 is still granted and consumed (ReqReady=1), but produces WritebackEn=0.
- Squash:
  - A speculative winner in a MispredictedSpeculationPulse cycle is consumed and dropped.
  - Non-speculative winners in that cycle are written normally.
  - Squash has no effect on the already-registered output.
- RR pointer: on a transfer it becomes (winner+1) mod NUMREQ; with no transfer it holds. Starvation bound: a continuously valid requester is granted within NUMREQ unblocked cycles.
- clk_en=0 or WritebackBlock=1: ReqReady=0 and no pointer change. With WritebackBlock=1 and clk_en=1, WritebackEn <= 0 next cycle.
- Reset mid-operation: a pending registered write is discarded (WritebackEn forced 0 immediately), and requesters must re-present.
- Single valid requester: granted every unblocked cycle, giving back-to-back writes.

Optional Feature:
- Macro WRITEBACK_ARB_PERF_EN.
- When defined:
  - Adds output ConflictCount [15:0]. It increments (saturating at 16'hFFFF) on each clk_en cycle with WritebackBlock=0 and two or more ReqValid bits set.
  - Adds output SquashCount [15:0]. It increments (saturating) on each squashed transfer.
  - Both counters reset to 0.
- When undefined: neither port nor counter logic exists, and arbitration behaviour is identical.

Test Plan:
- Reset, then ReqValid=4'b1111, all addrs distinct non-zero, clk_en=1 -> grants in order 0,1,2,3,0. WritebackEn=1 every cycle from cycle 1; each WritebackRegisterAddr/Data matches the requester granted one cycle earlier.
- ReqValid=4'b0100, ReqAddr[2]=4'd0 -> ReqReady=4'b0100, next-cycle WritebackEn=0, pointer becomes 3.
- ReqValid=4'b0011, ReqSpeculative=4'b0001, pointer=0, MispredictedSpeculationPulse=1 -> ReqReady=4'b0001, next WritebackEn=0. Following cycle grants req1 with WritebackEn=1.
- WritebackBlock=1 for 3 cycles with ReqValid=4'b1010 -> ReqReady=0 and WritebackEn=0 throughout. On release, req1 is granted first (pointer 0).
- async_rst_n driven low mid-cycle while WritebackEn=1 -> WritebackEn=0 immediately without a clock edge. After release, pointer=0.
- (WRITEBACK_ARB_PERF_EN) 5 cycles with ReqValid=4'b0110 -> ConflictCount=5. 2 squashed speculative transfers -> SquashCount=2.
